// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUCtrl codes,
// FSM state encoding and the opcode legality check.
package alu_arbiter_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_LW   = 4'b0011;
   localparam logic [3:0] ALU_MUL  = 4'b0100;
   localparam logic [3:0] ALU_SW   = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_ADDI = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_LW,
         ALU_MUL, ALU_SW, ALU_SUB, ALU_ADDI: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, on contention
// the requester that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_any,
   output logic       o_idx
);

   always_comb begin
      o_any = |i_req;
      o_idx = 1'b0;
      case (i_req)
         2'b10:   o_idx = 1'b1;
         2'b11:   o_idx = ~i_last;
         default: o_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU; holds operands
// through execution and returns the registered result to the granted requester.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 3,
   parameter logic        RR_INIT    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [7:0]  req_op_i,
   input  logic [63:0] req_a_i,
   input  logic [63:0] req_b_i,
   output logic [1:0]  rsp_valid_o,
   input  logic [1:0]  rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_zero_o,
   output logic        rsp_err_o,
   output logic [31:0] alu_data1_o,
   output logic [31:0] alu_data2_o,
   output logic [3:0]  alu_ctrl_o,
   input  logic [31:0] alu_data_i,
   input  logic        alu_zero_i
);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_lg;
   logic        r_owner;
   logic [3:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_data;
   logic        r_zero;
   logic        r_err;

   logic        w_any;
   logic        w_idx;
   logic        w_grant;
   logic [3:0]  w_sel_op;
   logic [31:0] w_sel_a;
   logic [31:0] w_sel_b;

   rr_arb2 u_rr (
      .i_req  (req_valid_i),
      .i_last (r_lg),
      .o_any  (w_any),
      .o_idx  (w_idx)
   );

   // Reset gates the grant so req_ready_o stays low while rst_i is asserted.
   assign w_grant  = (r_state == IDLE) && w_any && rst_i;
   assign w_sel_op = w_idx ? req_op_i[7:4]  : req_op_i[3:0];
   assign w_sel_a  = w_idx ? req_a_i[63:32] : req_a_i[31:0];
   assign w_sel_b  = w_idx ? req_b_i[63:32] : req_b_i[31:0];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_next      = EXEC;
               req_ready_o = w_idx ? 2'b10 : 2'b01;
            end
         end
         EXEC: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = r_owner ? 2'b10 : 2'b01;
            if (rsp_ready_i[r_owner]) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt   <= '0;
         r_lg    <= RR_INIT;
         r_owner <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_data  <= '0;
         r_zero  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_owner <= w_idx;
            r_lg    <= w_idx;
            r_cnt   <= (w_sel_op == ALU_MUL) ? 4'(MUL_CYCLES - 1) : 4'd0;
         end
         if (r_state == EXEC) begin
            if (r_cnt == 4'd0) begin
               // Unsupported opcodes never expose whatever the ALU produced.
               if (op_legal(r_op)) begin
                  r_data <= alu_data_i;
                  r_zero <= alu_zero_i;
                  r_err  <= 1'b0;
               end else begin
                  r_data <= '0;
                  r_zero <= 1'b0;
                  r_err  <= 1'b1;
               end
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
         end
      end
   end

   assign alu_ctrl_o  = (r_state == IDLE) ? 4'b0000 : r_op;
   assign alu_data1_o = (r_state == IDLE) ? 32'h0   : r_a;
   assign alu_data2_o = (r_state == IDLE) ? 32'h0   : r_b;

   assign rsp_data_o  = r_data;
   assign rsp_zero_o  = r_zero;
   assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_arbiter;

   localparam int unsigned MULC = 3;
   localparam logic        RRI  = 1'b1;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [7:0]  req_op_i;
   logic [63:0] req_a_i;
   logic [63:0] req_b_i;
   logic [1:0]  rsp_valid_o;
   logic [1:0]  rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic        rsp_zero_o;
   logic        rsp_err_o;
   logic [31:0] alu_data1_o;
   logic [31:0] alu_data2_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_data_i;
   logic        alu_zero_i;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arbiter #(.MUL_CYCLES(MULC), .RR_INIT(RRI)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_op_i    (req_op_i),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_zero_o  (rsp_zero_o),
      .rsp_err_o   (rsp_err_o),
      .alu_data1_o (alu_data1_o),
      .alu_data2_o (alu_data2_o),
      .alu_ctrl_o  (alu_ctrl_o),
      .alu_data_i  (alu_data_i),
      .alu_zero_i  (alu_zero_i)
   );

   always #5 clk_i = ~clk_i;

   // External ALU: 33-bit result, bit 32 reported on Zero_o; junk for unknown codes.
   function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         4'b0000:                   return {1'b0, a & b};
         4'b0001:                   return {1'b0, a | b};
         4'b0010, 4'b0011,
         4'b0101, 4'b1000:          return {1'b0, a} + {1'b0, b};
         4'b0100:                   return p[32:0];
         4'b0110:                   return {1'b0, a} - {1'b0, b};
         default:                   return 33'h1_5A5A_A5A5;
      endcase
   endfunction

   logic [32:0] w_alu;
   always_comb begin
      w_alu      = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);
      alu_data_i = w_alu[31:0];
      alu_zero_i = w_alu[32];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model, checked on every falling edge ----------
   bit          m_busy  = 1'b0;
   bit          m_lg    = RRI;
   bit          m_owner = 1'b0;
   int          m_wait  = 0;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b, m_data;
   logic        m_zero, m_err;

   always @(negedge clk_i) begin
      logic [1:0]  e_ready, e_rv;
      logic [3:0]  e_ctrl;
      logic [31:0] e_d1, e_d2;
      logic [32:0] r;
      bit          gi;
      if (!rst_i) begin
         check("rst_ready", req_ready_o, 2'b00);
         check("rst_rvalid", rsp_valid_o, 2'b00);
         check("rst_data", rsp_data_o, 32'h0);
         check("rst_zero", rsp_zero_o, 1'b0);
         check("rst_err", rsp_err_o, 1'b0);
         check("rst_ctrl", alu_ctrl_o, 4'h0);
         m_busy = 1'b0;
         m_lg   = RRI;
      end else begin
         e_ready = 2'b00;
         e_rv    = 2'b00;
         e_ctrl  = 4'h0;
         e_d1    = 32'h0;
         e_d2    = 32'h0;
         gi      = (req_valid_i == 2'b11) ? !m_lg : req_valid_i[1];
         if (!m_busy) begin
            if (req_valid_i != 2'b00) e_ready = gi ? 2'b10 : 2'b01;
         end else begin
            e_ctrl = m_op;
            e_d1   = m_a;
            e_d2   = m_b;
            if (m_wait == 0) e_rv = m_owner ? 2'b10 : 2'b01;
         end
         check("m_ready", req_ready_o, e_ready);
         check("m_rvalid", rsp_valid_o, e_rv);
         check("m_ctrl", alu_ctrl_o, e_ctrl);
         check("m_d1", alu_data1_o, e_d1);
         check("m_d2", alu_data2_o, e_d2);
         if (e_rv != 2'b00) begin
            check("m_data", rsp_data_o, m_data);
            check("m_zero", rsp_zero_o, m_zero);
            check("m_err", rsp_err_o, m_err);
         end
         // advance to the state after the coming rising edge
         if (!m_busy) begin
            if (req_valid_i != 2'b00) begin
               m_busy  = 1'b1;
               m_owner = gi;
               m_lg    = gi;
               m_op    = gi ? req_op_i[7:4]  : req_op_i[3:0];
               m_a     = gi ? req_a_i[63:32] : req_a_i[31:0];
               m_b     = gi ? req_b_i[63:32] : req_b_i[31:0];
               m_wait  = (m_op == 4'b0100) ? int'(MULC) : 1;
               if (m_op <= 4'd6 || m_op == 4'd8) begin
                  r      = alu_fn(m_op, m_a, m_b);
                  m_data = r[31:0];
                  m_zero = r[32];
                  m_err  = 1'b0;
               end else begin
                  m_data = 32'h0;
                  m_zero = 1'b0;
                  m_err  = 1'b1;
               end
            end
         end else if (m_wait > 0) begin
            m_wait--;
         end else if (rsp_ready_i[m_owner]) begin
            m_busy = 1'b0;
         end
      end
   end

   // ---------------- stimulus and literal expectations ------------------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [3:0] rand_op();
      return ($urandom % 4 == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
   endfunction

   initial begin
      logic [31:0] held;
      bit          gq[$];
      req_valid_i = 2'b11;
      req_op_i    = 8'h00;
      req_a_i     = 64'h0;
      req_b_i     = 64'h0;
      rsp_ready_i = 2'b11;
      #2;
      check("reset_ready", req_ready_o, 2'b00);
      check("reset_rvalid", rsp_valid_o, 2'b00);
      step();
      step();
      rst_i       = 1'b1;

      // single add, granted on the first edge after release
      req_valid_i = 2'b01;
      req_op_i    = 8'h08;
      req_a_i     = 64'd5;
      req_b_i     = 64'd7;
      #1 check("add_ready", req_ready_o, 2'b01);
      step();
      req_valid_i = 2'b00;
      #1 check("add_t1_rvalid", rsp_valid_o, 2'b00);
      check("add_exec_d1", alu_data1_o, 32'd5);
      step();
      #1 check("add_rvalid", rsp_valid_o, 2'b01);
      check("add_data", rsp_data_o, 32'd12);
      check("add_zero", rsp_zero_o, 1'b0);
      check("add_err", rsp_err_o, 1'b0);
      step();
      #1 check("idle_ctrl", alu_ctrl_o, 4'h0);
      check("idle_d2", alu_data2_o, 32'h0);

      // multiply from requester 1
      req_valid_i = 2'b10;
      req_op_i    = 8'h40;
      req_a_i     = {32'd6, 32'd0};
      req_b_i     = {32'd7, 32'd0};
      #1 check("mul_ready", req_ready_o, 2'b10);
      for (int i = 1; i <= 3; i++) begin
         step();
         req_valid_i = 2'b00;
         #1 check("mul_wait", rsp_valid_o, 2'b00);
      end
      step();
      #1 check("mul_rvalid", rsp_valid_o, 2'b10);
      check("mul_data", rsp_data_o, 32'd42);
      step();

      // unsupported opcode
      req_valid_i = 2'b01;
      req_op_i    = 8'h0F;
      req_a_i     = 64'h1234;
      #1 check("ill_ready", req_ready_o, 2'b01);
      step();
      req_valid_i = 2'b00;
      #1 check("ill_t1", rsp_valid_o, 2'b00);
      step();
      #1 check("ill_rvalid", rsp_valid_o, 2'b01);
      check("ill_data", rsp_data_o, 32'h0);
      check("ill_err", rsp_err_o, 1'b1);
      step();

      // backpressure from requester 0; requester 1's response-ready is ignored
      req_valid_i = 2'b01;
      req_op_i    = 8'h02;
      req_a_i     = 64'd100;
      req_b_i     = 64'd23;
      rsp_ready_i = 2'b10;
      #1 check("bp_ready", req_ready_o, 2'b01);
      step();
      req_valid_i = 2'b10;
      step();
      #1 check("bp_rvalid", rsp_valid_o, 2'b01);
      held = rsp_data_o;
      check("bp_data", rsp_data_o, 32'd123);
      for (int i = 0; i < 4; i++) begin
         step();
         #1 check("bp_hold_rv", rsp_valid_o, 2'b01);
         check("bp_hold_data", rsp_data_o, held);
         check("bp_no_r1", req_ready_o, 2'b00);
      end
      step();
      rsp_ready_i = 2'b11;
      #1 check("bp_accept_rv", rsp_valid_o, 2'b01);
      check("bp_accept_no_r1", req_ready_o, 2'b00);
      step();
      #1 check("bp_r1_ready", req_ready_o, 2'b10);
      step();
      req_valid_i = 2'b00;
      step();
      step();
      step();

      // contention from reset: strict alternation starting with requester 0
      rst_i = 1'b0;
      step();
      rst_i       = 1'b1;
      req_valid_i = 2'b11;
      req_op_i    = 8'h22;
      #1;
      for (int i = 0; i < 12; i++) begin
         if (req_ready_o != 2'b00) gq.push_back(req_ready_o[1]);
         step();
         #1;
      end
      check("cont_count", gq.size() >= 4, 1'b1);
      if (gq.size() >= 4) begin
         check("cont_g0", gq[0], 1'b0);
         check("cont_g1", gq[1], 1'b1);
         check("cont_g2", gq[2], 1'b0);
         check("cont_g3", gq[3], 1'b1);
      end
      req_valid_i = 2'b00;
      for (int i = 0; i < 4; i++) step();

      // reset during multiply execution
      req_valid_i = 2'b01;
      req_op_i    = 8'h04;
      req_a_i     = 64'd3;
      req_b_i     = 64'd3;
      #1 check("rm_ready", req_ready_o, 2'b01);
      step();
      req_valid_i = 2'b00;
      rst_i       = 1'b0;
      #1 check("rm_ctrl", alu_ctrl_o, 4'h0);
      check("rm_d1", alu_data1_o, 32'h0);
      check("rm_rvalid", rsp_valid_o, 2'b00);
      step();
      step();
      rst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         #1 check("rm_no_rsp", rsp_valid_o, 2'b00);
      end
      req_valid_i = 2'b01;
      req_op_i    = 8'h02;
      #1 check("rm_regrant", req_ready_o, 2'b01);
      step();
      req_valid_i = 2'b00;
      for (int i = 0; i < 3; i++) step();

      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!rst_i) rst_i = ($urandom % 2 == 0);
         else if ($urandom % 300 == 0) rst_i = 1'b0;
         req_valid_i = 2'($urandom);
         req_op_i    = {rand_op(), rand_op()};
         req_a_i     = {$urandom, $urandom};
         req_b_i     = {($urandom % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom};
         rsp_ready_i = ($urandom % 3 == 0) ? 2'b00 : 2'($urandom);
      end
      rst_i       = 1'b1;
      req_valid_i = 2'b00;
      rsp_ready_i = 2'b11;
      for (int i = 0; i < 20; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL expose parameter MUL_CYCLES, default 3, meaning the EXEC cycles held for multiply (ALUCtrl 4'b0100); legal range 1..15.
REQ-002 The block SHALL expose parameter RR_INIT, default 1'b1, meaning the initial value of the last-granted pointer, so requester 0 wins first.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  2  per-requester request valid; bit n is requester n.
REQ-006 req_ready_o  output  2  per-requester request accepted this cycle.
REQ-007 req_op_i  input  8  two 4-bit ALUCtrl codes; [3:0] is requester 0, [7:4] is requester 1.
REQ-008 req_a_i, req_b_i  input  64 each  two 32-bit operand pairs, packed as for req_op_i.
REQ-009 rsp_valid_o  output  2  one-hot response valid to the owning requester.
REQ-010 rsp_ready_i  input  2  per-requester response accept.
REQ-011 rsp_data_o  output  32  result shared by both requesters; qualified by rsp_valid_o.
REQ-012 rsp_zero_o  output  1  registered ALU Zero_o (bit 32 of the result); qualified by rsp_valid_o.
REQ-013 rsp_err_o  output  1  unsupported opcode flag; qualified by rsp_valid_o.
REQ-014 alu_data1_o, alu_data2_o  output  32 each  operands driven to the shared ALU.
REQ-015 alu_ctrl_o  output  4  ALUCtrl driven to the shared ALU.
REQ-016 alu_data_i  input  32  ALU data_o.
REQ-017 alu_zero_i  input  1  ALU Zero_o.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, plus a cycle counter cnt[3:0] and a last-granted pointer lg.
REQ-019 In IDLE with any req_valid_i set, the block SHALL grant one requester: the single requester if only one is valid, otherwise requester ~lg.
REQ-020 The grant SHALL assert req_ready_o for exactly one cycle, combinationally, only in IDLE.
REQ-021 On grant, the block SHALL latch op/a/b into operand registers, set owner and lg to the granted index, load cnt, and enter EXEC.
REQ-022 cnt SHALL load MUL_CYCLES-1 for op 4'b0100 and 0 otherwise.
REQ-023 alu_data1_o, alu_data2_o and alu_ctrl_o SHALL be driven from the operand registers, stable throughout EXEC and RESP.
REQ-024 In IDLE, alu_ctrl_o SHALL be 4'b0000 and the data outputs SHALL be 0.
REQ-025 In EXEC with cnt==0, the block SHALL capture alu_data_i and alu_zero_i into the result registers and enter RESP; otherwise it SHALL decrement cnt.
REQ-026 Legal opcodes are 0000, 0001, 0010, 0011, 0100, 0101, 0110 and 1000.
REQ-027 For any other opcode, the block SHALL capture data 0, zero 0 and err 1, taking a 1-cycle EXEC.
REQ-028 In RESP, rsp_valid_o[owner] SHALL stay high, with data/zero/err stable, until rsp_ready_i[owner] is high; the block then returns to IDLE on the next edge.
REQ-029 rsp_ready_i of the non-owner SHALL be ignored.
REQ-030 Latency SHALL be: non-mul request accepted at cycle t gives rsp_valid at t+2; mul gives t+1+MUL_CYCLES.
REQ-031 Throughput SHALL be at most one accept per (EXEC length + 2) cycles; no grant is made in RESP, even in the same cycle rsp_ready_i is seen.
REQ-032 If both requesters hold valid continuously, grants SHALL strictly alternate.
REQ-033 A requester dropping valid before its ready SHALL lose nothing and cause no grant; valid is sampled only in IDLE.
REQ-034 No arithmetic SHALL be performed in the block: the ALU result is taken as-is, including the 33-bit carry behaviour in zero.

Reset
REQ-035 Reset assertion SHALL immediately force state IDLE, cnt 0, lg RR_INIT, owner 0, and operand and result registers 0.
REQ-036 During reset, req_ready_o, rsp_valid_o, rsp_err_o and rsp_zero_o SHALL be 0, and rsp_data_o SHALL be 32'h0.
REQ-037 Reset mid-EXEC or mid-RESP SHALL discard the transaction with no response issued.
REQ-038 After reset release, the first grant SHALL be possible on the first rising edge.

Structure
REQ-039 A shared package SHALL hold the ALUCtrl code constants (ADD, SUB, AND, OR, MUL, LW, SW, ADDI), the FSM state encoding (2 bits) and the opcode-legality function.
REQ-040 No sub-module is required; the round-robin picker MAY be a sub-module named rr_arb2.

Verification
REQ-041 Single add: r0 valid, op 1000, a=5, b=7; ALU model returns 12 -> ready r0 at t, rsp_valid=2'b01 at t+2, data 12, zero 0, err 0.
REQ-042 Mul latency with MUL_CYCLES=3: r1 op 0100, a=6, b=7 -> rsp_valid=2'b10 at t+4, data 42.
REQ-043 Contention: both valid continuously, rsp_ready tied high -> grant order r0, r1, r0, r1 from reset.
REQ-044 Backpressure: r0 rsp_ready low 5 cycles while r1 valid -> response held stable, no r1 ready until the cycle after r0 accepts.
REQ-045 Illegal op 4'b1111 -> response data 0, err 1, at t+2.
REQ-046 Reset asserted during mul EXEC -> outputs zero immediately; no rsp_valid after release; next request from r0 is granted.
